// File: rtl/ram_stream_reader.sv
// ram_stream_reader: bursts reads from a 1-cycle-latency RAM port into a
// 2-entry fall-through FIFO and streams them out with a running checksum.
module ram_stream_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              ram_enb,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_doutb,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);
    localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, FINISH = 2'd3;
    logic [1:0]        r_state, r_cnt, w_next, w_outstanding;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remain;
    logic              r_inflight, r_wp, r_rp;
    logic [DATA_W-1:0] r_mem [2];
    logic [DATA_W-1:0] r_sum;
    logic              w_enb, w_acc, w_push, w_pop;
    assign w_outstanding = r_cnt + {1'b0, r_inflight};
    assign w_enb     = !rst && r_state == READ && r_remain != '0 && w_outstanding < 2'd2;
    assign out_valid = !rst && w_outstanding != 2'd0;
    // An empty FIFO passes returning RAM data straight through for minimum latency.
    assign out_data  = r_cnt != 2'd0 ? r_mem[r_rp] : (r_inflight ? ram_doutb : '0);
    assign w_acc     = out_valid && out_ready;
    assign w_pop     = r_cnt != 2'd0 && out_ready;
    assign w_push    = r_inflight && !(r_cnt == 2'd0 && out_ready);
    assign ram_enb   = w_enb;
    assign ram_addrb = r_addr;
    assign busy      = !rst && r_state != IDLE;
    assign done      = !rst && r_state == FINISH;
    assign checksum  = r_sum;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = length == '0 ? FINISH : READ;
            READ:    if (w_enb && r_remain == (ADDR_W+1)'(1)) w_next = DRAIN;
            DRAIN:   if (w_acc && w_outstanding == 2'd1) w_next = FINISH;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wp] <= ram_doutb;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_remain   <= '0;
            r_inflight <= 1'b0;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_sum      <= '0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_enb;
            r_cnt      <= r_cnt + 2'(w_push) - 2'(w_pop);
            if (w_push) r_wp <= ~r_wp;
            if (w_pop) r_rp <= ~r_rp;
            if (w_acc) r_sum <= r_sum + out_data;
            if (w_enb) begin
                r_addr   <= r_addr + ADDR_W'(1);
                r_remain <= r_remain - (ADDR_W+1)'(1);
            end
            if (r_state == IDLE && start) begin
                r_addr   <= base_addr;
                r_remain <= length;
                r_sum    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: table of bursts against a preloaded RAM model,
// plus hand-written reset and start-collision sequences.
module tb_ram_stream_reader;
    localparam int AW = 4, DW = 32;
    logic          clk = 1'b0, rst, start, out_ready;
    logic [AW-1:0] base_addr, ram_addrb;
    logic [AW:0]   length;
    logic          ram_enb, out_valid, busy, done;
    logic [DW-1:0] ram_doutb = '0, out_data, checksum;
    logic [DW-1:0] mem [16];
    int            n_vec = 0, n_bad = 0;

    typedef struct {
        logic [3:0]  base;
        logic [4:0]  len;
        logic [3:0]  pat;
        int          restart;
        logic [31:0] sum;
        int          done_c;
    } vec_t;
    vec_t vecs [9];

    ram_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (ram_enb) ram_doutb <= mem[ram_addrb];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_burst(input vec_t v);
        int k = 0, issued = 0, max_out = 0, busy_n = 0, done_c = -1;
        logic stall = 1'b0;
        logic [31:0] held = '0;
        for (int c = 0; c < 80 && done_c < 0; c++) begin
            @(negedge clk);
            start     = (c == 0) || (v.restart > 0 && c == v.restart);
            base_addr = c == 0 ? v.base : 4'd9;
            length    = c == 0 ? v.len : 5'd1;
            out_ready = v.pat[c % 4];
            #1;
            if (c == 0) chk("idle_busy", busy, 0);
            if (stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, held);
            end
            stall = out_valid && !out_ready;
            held  = out_data;
            if (ram_enb) begin
                chk("addr", ram_addrb, 4'(v.base + issued));
                issued++;
            end
            if (out_valid && out_ready) begin
                chk("data", out_data, ((v.base + k) & 15) + 1);
                if (k == 0 && v.pat == 4'hf) chk("first_latency", c, 2);
                k++;
            end
            if (issued - k > max_out) max_out = issued - k;
            busy_n += busy;
            if (done) begin
                done_c = c;
                chk("checksum", checksum, v.sum);
            end
        end
        start = 1'b0;
        chk("done_seen", done_c >= 0, 1);
        chk("words", k, v.len);
        chk("issued", issued, v.len);
        chk("outstanding_le2", max_out <= 2, 1);
        chk("busy_cycles", busy_n, done_c);
        if (v.done_c >= 0) chk("done_cycle", done_c, v.done_c);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("done_one_cycle", done, 0);
        chk("idle_after", busy, 0);
        chk("sum_hold", checksum, v.sum);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = i + 1;
        vecs[0] = '{4'd0,  5'd2,  4'hf,    0, 32'd3,   4};
        vecs[1] = '{4'd2,  5'd4,  4'hf,    0, 32'd18,  6};
        vecs[2] = '{4'd14, 5'd4,  4'hf,    0, 32'd34,  6};
        vecs[3] = '{4'd0,  5'd0,  4'hf,    0, 32'd0,   1};
        vecs[4] = '{4'd0,  5'd8,  4'b1001, 0, 32'd36, -1};
        vecs[5] = '{4'd5,  5'd16, 4'hf,    0, 32'd136, 18};
        vecs[6] = '{4'd2,  5'd4,  4'hf,    3, 32'd18,  6};
        vecs[7] = '{4'd3,  5'd2,  4'b0100, 0, 32'd9,  -1};
        vecs[8] = '{4'd15, 5'd1,  4'hf,    0, 32'd16,  3};
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; length = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_enb", ram_enb, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", ram_addrb, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sum", checksum, 0);
        @(negedge clk);
        rst = 1'b0; start = 1'b1; base_addr = 4'd4; length = 5'd8; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_enb", ram_enb, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_enb", ram_enb, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_addr", ram_addrb, 0);
        chk("abort_data", out_data, 0);
        chk("abort_sum", checksum, 0);
        for (int i = 0; i < 9; i++) run_burst(vecs[i]);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; base_addr = 4'd0; length = 5'd3;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        chk("rst_over_start_busy", busy, 0);
        chk("rst_over_start_enb", ram_enb, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
